write_back: RTL

WRITE_BACK -- requirements
Module: write_back

---
 rtl/write_back_pkg.sv | 32 +++
 rtl/wb_rf_mux.sv | 31 +++
 rtl/write_back.sv | 111 +++++++++++
 3 files changed

// File: rtl/write_back_pkg.sv
// rtl/write_back_pkg.sv - shared ISA constants and stage-register type for the write-back stage
package write_back_pkg;

    localparam logic [31:0] INST_NOP = 32'h83FF_F800;  // ADD R31,R31,R31
    localparam int          RC_HI    = 25;
    localparam int          RC_LO    = 21;
    localparam logic [4:0]  REG_R31  = 5'd31;
    localparam logic [4:0]  REG_XP   = 5'd30;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] y;
        logic        op_ld_or_ldr;
        logic        op_st;
        logic        rf_w_mux_jump;
    } wb_stage_t;

    localparam wb_stage_t WB_STAGE_RESET = '{
        pc:            32'h0,
        ir:            INST_NOP,
        y:             32'h0,
        op_ld_or_ldr:  1'b0,
        op_st:         1'b0,
        rf_w_mux_jump: 1'b0
    };

    function automatic logic [4:0] ir_rc(input logic [31:0] ir);
        return ir[RC_HI:RC_LO];
    endfunction

endpackage

// File: rtl/wb_rf_mux.sv
// rtl/wb_rf_mux.sv - register-file write data select and write enable for the write-back stage
module wb_rf_mux
    import write_back_pkg::*;
(
    input  logic [31:0] pc_wb,
    input  logic [31:0] y_wb,
    input  logic [4:0]  rc_wb,
    input  logic        op_ld_or_ldr_wb,
    input  logic        op_st_wb,
    input  logic        rf_w_mux_jump_wb,
    input  logic [31:0] mem_r_data,
    input  logic        load_wait,
    output logic        rf_w_en,
    output logic [4:0]  rf_w_addr,
    output logic [31:0] rf_w_data
);

    always_comb begin
        rf_w_addr = rc_wb;
        // Jumps (including the exception BNE into XP) take priority over load data
        if (rf_w_mux_jump_wb) begin
            rf_w_data = pc_wb;
        end else if (op_ld_or_ldr_wb) begin
            rf_w_data = mem_r_data;
        end else begin
            rf_w_data = y_wb;
        end
        rf_w_en = !op_st_wb && !load_wait && (rc_wb != REG_R31);
    end

endmodule

// File: rtl/write_back.sv
// rtl/write_back.sv - pipeline write-back stage with load-wait stall and retirement counter
module write_back
    import write_back_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic [31:0] ir,
    input  logic [31:0] y,
    input  logic        op_ld_or_ldr,
    input  logic        op_st,
    input  logic        rf_w_mux_jump,
    input  logic [31:0] mem_r_data,
    input  logic        mem_r_valid,
    output logic        rf_w_en,
    output logic [4:0]  rf_w_addr,
    output logic [31:0] rf_w_data,
    output logic        wb_stall,
    output logic        byp_valid,
    output logic [4:0]  byp_addr,
    output logic [31:0] byp_data,
    output logic [31:0] instr_retired
);

    typedef enum logic {
        RUN,
        LD_WAIT
    } wb_state_t;

    wb_state_t state_q, state_d;
    wb_stage_t stg_q;
    logic [31:0] retired_q;
    logic        retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_q <= WB_STAGE_RESET;
        end else if (!wb_stall) begin
            stg_q <= '{
                pc:            pc,
                ir:            ir,
                y:             y,
                op_ld_or_ldr:  op_ld_or_ldr,
                op_st:         op_st,
                rf_w_mux_jump: rf_w_mux_jump
            };
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Stall lasts only while the load data is missing; valid data completes the load in-cycle
    always_comb begin
        state_d  = state_q;
        wb_stall = 1'b0;
        case (state_q)
            RUN: begin
                if (stg_q.op_ld_or_ldr && !mem_r_valid) begin
                    wb_stall = 1'b1;
                    state_d  = LD_WAIT;
                end
            end
            LD_WAIT: begin
                if (mem_r_valid) begin
                    state_d = RUN;
                end else begin
                    wb_stall = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    wb_rf_mux u_rf_mux (
        .pc_wb            (stg_q.pc),
        .y_wb             (stg_q.y),
        .rc_wb            (ir_rc(stg_q.ir)),
        .op_ld_or_ldr_wb  (stg_q.op_ld_or_ldr),
        .op_st_wb         (stg_q.op_st),
        .rf_w_mux_jump_wb (stg_q.rf_w_mux_jump),
        .mem_r_data       (mem_r_data),
        .load_wait        (wb_stall),
        .rf_w_en          (rf_w_en),
        .rf_w_addr        (rf_w_addr),
        .rf_w_data        (rf_w_data)
    );

    assign byp_valid = rf_w_en;
    assign byp_addr  = rf_w_addr;
    assign byp_data  = rf_w_data;

    // An instruction completes when it writes or is a store; NOP bubbles never count
    assign retire = (rf_w_en || (stg_q.op_st && !wb_stall)) && (stg_q.ir != INST_NOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 32'h0;
        end else if (retire) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign instr_retired = retired_q;

endmodule
